// File: rtl/chip8_fb_pkg.sv
// Shared framebuffer geometry, blitter state encoding and address helper
// for the Chip-8 display path.
package chip8_fb_pkg;

  localparam int FB_AW     = 9;
  localparam int FB_DW     = 16;
  localparam int MEM_AW    = 12;
  localparam int ROW_WORDS = 8;

  localparam int W_HI = 128;
  localparam int H_HI = 64;
  localparam int C_HI = 8;
  localparam int W_LO = 64;
  localparam int H_LO = 32;
  localparam int C_LO = 4;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH0,
    ST_FETCH1,
    ST_FETCH2,
    ST_RD0,
    ST_RD1,
    ST_WR0,
    ST_WR1,
    ST_DONE
  } state_t;

  // Lores shares the hires stride, so only the row count differs per mode.
  function automatic logic [FB_AW-1:0] fb_addr(input logic [5:0] row, input logic [2:0] col);
    return FB_AW'(row) * FB_AW'(ROW_WORDS) + FB_AW'(col);
  endfunction

endpackage

// File: rtl/sprite_align.sv
// Aligns a 16-bit sprite row to the framebuffer word grid: the row is placed
// at pixel offset off, split across the word it starts in and the next one.
module sprite_align
  import chip8_fb_pkg::*;
(
  input  logic [FB_DW-1:0] s,
  input  logic [3:0]       off,
  output logic [FB_DW-1:0] m0,
  output logic [FB_DW-1:0] m1
);

  logic [2*FB_DW-1:0] m;

  always_comb begin
    m  = {s, {FB_DW{1'b0}}} >> off;
    m0 = m[2*FB_DW-1:FB_DW];
    m1 = m[FB_DW-1:0];
  end

endmodule

// File: rtl/sprite_blitter.sv
// DXYN sprite draw engine: fetches sprite bytes and XORs them into the
// framebuffer by read-modify-write. Define SPRITE_WRAP_EN for wrap-around edges.
module sprite_blitter
  import chip8_fb_pkg::*;
(
  input  logic              clk,
  input  logic              res,
  input  logic              hires,
  input  logic              start,
  input  logic [6:0]        x,
  input  logic [5:0]        y,
  input  logic [3:0]        n,
  input  logic [MEM_AW-1:0] i_addr,
  output logic              busy,
  output logic              done,
  output logic              collision,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_data,
  output logic [FB_AW-1:0]  fbuf_addr,
  output logic              fbuf_we,
  output logic [FB_DW-1:0]  fbuf_wdata,
  input  logic [FB_DW-1:0]  fbuf_rdata
);

  state_t            state;
  logic              hires_l;
  logic              wide;
  logic [6:0]        x_l;
  logic [5:0]        y_l;
  logic [3:0]        n_l;
  logic [MEM_AW-1:0] ptr;
  logic [4:0]        row;
  logic [7:0]        b0;
  logic [7:0]        b1;

  logic [FB_DW-1:0]  sprite_s;
  logic [FB_DW-1:0]  m0;
  logic [FB_DW-1:0]  m1;
  logic [2:0]        col0;
  logic [2:0]        col1;
  logic [3:0]        c_lim;
  logic              col1_ok;
  logic              row_ok;
  logic              nrow_ok;
  logic              last_row;
  logic [4:0]        rows;
  logic [6:0]        yr;
  logic [5:0]        row_addr;
  logic [MEM_AW-1:0] ptr_next;
  logic [FB_AW-1:0]  a0;
  logic [FB_AW-1:0]  a1;

  sprite_align u_align (
    .s   (sprite_s),
    .off (x_l[3:0]),
    .m0  (m0),
    .m1  (m1)
  );

  always_comb begin
    sprite_s = wide ? {b0, b1} : {b0, 8'h00};
    rows     = wide ? 5'd16 : {1'b0, n_l};
    last_row = (row + 5'd1) == rows;
    ptr_next = ptr + (wide ? MEM_AW'(2) : MEM_AW'(1));
    col0     = x_l[6:4];
    c_lim    = hires_l ? 4'(C_HI) : 4'(C_LO);
    yr       = {1'b0, y_l} + {2'b00, row};
`ifdef SPRITE_WRAP_EN
    col1     = (col0 + 3'd1) & 3'(c_lim - 4'd1);
    col1_ok  = 1'b1;
    row_ok   = 1'b1;
    nrow_ok  = 1'b1;
    row_addr = hires_l ? yr[5:0] : {1'b0, yr[4:0]};
`else
    col1     = col0 + 3'd1;
    col1_ok  = ({1'b0, col0} + 4'd1) < c_lim;
    row_ok   = yr < (hires_l ? 7'(H_HI) : 7'(H_LO));
    nrow_ok  = (yr + 7'd1) < (hires_l ? 7'(H_HI) : 7'(H_LO));
    row_addr = yr[5:0];
`endif
    a0 = fb_addr(row_addr, col0);
    a1 = fb_addr(row_addr, col1);
  end

  // Write data is formed from fbuf_rdata on the edge that enters WR0/WR1,
  // so each write is driven during its own state and a reset there kills it.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      collision  <= 1'b0;
      mem_addr   <= '0;
      mem_rd     <= 1'b0;
      fbuf_addr  <= '0;
      fbuf_we    <= 1'b0;
      fbuf_wdata <= '0;
      hires_l    <= 1'b0;
      wide       <= 1'b0;
      x_l        <= '0;
      y_l        <= '0;
      n_l        <= '0;
      ptr        <= '0;
      row        <= '0;
      b0         <= '0;
      b1         <= '0;
    end else begin
      mem_rd  <= 1'b0;
      fbuf_we <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            hires_l   <= hires;
            x_l       <= x & 7'((hires ? W_HI : W_LO) - 1);
            y_l       <= y & 6'((hires ? H_HI : H_LO) - 1);
            n_l       <= n;
            wide      <= (n == 4'd0);
            ptr       <= i_addr;
            row       <= '0;
            collision <= 1'b0;
            busy      <= 1'b1;
            mem_addr  <= i_addr;
            mem_rd    <= 1'b1;
            state     <= ST_FETCH0;
          end
        end
        ST_FETCH0: begin
          if (!row_ok) begin
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            if (wide) begin
              mem_addr <= ptr + MEM_AW'(1);
              mem_rd   <= 1'b1;
            end
            state <= ST_FETCH1;
          end
        end
        ST_FETCH1: begin
          b0 <= mem_data;
          if (wide) begin
            state <= ST_FETCH2;
          end else begin
            fbuf_addr <= a0;
            state     <= ST_RD0;
          end
        end
        ST_FETCH2: begin
          b1        <= mem_data;
          fbuf_addr <= a0;
          state     <= ST_RD0;
        end
        ST_RD0: begin
          fbuf_addr <= a1;
          state     <= ST_RD1;
        end
        ST_RD1: begin
          fbuf_addr  <= a0;
          fbuf_we    <= 1'b1;
          fbuf_wdata <= fbuf_rdata ^ m0;
          if (|(fbuf_rdata & m0)) collision <= 1'b1;
          state <= ST_WR0;
        end
        ST_WR0: begin
          fbuf_addr <= a1;
          if (col1_ok) begin
            fbuf_we    <= 1'b1;
            fbuf_wdata <= fbuf_rdata ^ m1;
            if (|(fbuf_rdata & m1)) collision <= 1'b1;
          end
          state <= ST_WR1;
        end
        ST_WR1: begin
          ptr <= ptr_next;
          row <= row + 5'd1;
          if (last_row) begin
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            mem_addr <= ptr_next;
            mem_rd   <= nrow_ok;
            state    <= ST_FETCH0;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// Self-checking bench for sprite_blitter: table-driven draws against constant
// expectations and a pixel-level framebuffer model, plus reset and random draws.
module tb_sprite_blitter;

  logic        clk = 1'b0;
  logic        res;
  logic        hires;
  logic        start;
  logic [6:0]  x;
  logic [5:0]  y;
  logic [3:0]  n;
  logic [11:0] i_addr;
  logic        busy;
  logic        done;
  logic        collision;
  logic [11:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_data;
  logic [8:0]  fbuf_addr;
  logic        fbuf_we;
  logic [15:0] fbuf_wdata;
  logic [15:0] fbuf_rdata;

  sprite_blitter dut (
    .clk        (clk),
    .res        (res),
    .hires      (hires),
    .start      (start),
    .x          (x),
    .y          (y),
    .n          (n),
    .i_addr     (i_addr),
    .busy       (busy),
    .done       (done),
    .collision  (collision),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_data   (mem_data),
    .fbuf_addr  (fbuf_addr),
    .fbuf_we    (fbuf_we),
    .fbuf_wdata (fbuf_wdata),
    .fbuf_rdata (fbuf_rdata)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem    [0:4095];
  logic [15:0] fb     [0:511];
  logic [15:0] ref_fb [0:511];
  logic        fb_clr = 1'b0;

  always @(posedge clk) begin
    if (mem_rd) mem_data <= mem[mem_addr];
    fbuf_rdata <= fb[fbuf_addr];
    if (fb_clr) begin
      for (int i = 0; i < 512; i++) fb[i] <= '0;
    end else if (fbuf_we) begin
      fb[fbuf_addr] <= fbuf_wdata;
    end
  end

  int unsigned we_viol = 0;
  always @(negedge clk) begin
    if (res && fbuf_we && !busy) we_viol <= we_viol + 1;
  end

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  typedef struct {
    int unsigned cyc;
    bit          coll;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    bit          clr;
    bit          hi;
    logic [6:0]  x;
    logic [5:0]  y;
    logic [3:0]  n;
    logic [11:0] base;
    int unsigned cyc;
    bit          coll;
    logic [8:0]  a0;
    logic [15:0] v0;
    logic [8:0]  a1;
    logic [15:0] v1;
  } vec_t;
  vec_t tbl [7];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_fb();
    fb_clr = 1'b1;
    @(posedge clk);
    #1 fb_clr = 1'b0;
    for (int i = 0; i < 512; i++) ref_fb[i] = '0;
  endtask

  // Pixel-by-pixel reference: each set sprite pixel toggles one fb bit.
  task automatic model_draw(input bit hi, input logic [6:0] xi, input logic [5:0] yi,
                            input logic [3:0] ni, input logic [11:0] base,
                            output bit coll, output int unsigned cyc);
    int unsigned w, h, rows, bw, x0, y0, drawn, px, py, wd, bp, per;
    bit          clipped, skip;
    logic [15:0] bits;
    logic [11:0] a;
    w = hi ? 128 : 64;
    h = hi ? 64 : 32;
    rows = (ni == 4'd0) ? 16 : int'(ni);
    bw = (ni == 4'd0) ? 16 : 8;
    per = (ni == 4'd0) ? 7 : 6;
    x0 = xi % w;
    y0 = yi % h;
    drawn = 0;
    clipped = 0;
    coll = 0;
    for (int unsigned r = 0; r < rows && !clipped; r++) begin
      py = y0 + r;
      if (py >= h) begin
`ifdef SPRITE_WRAP_EN
        py = py - h;
`else
        clipped = 1;
`endif
      end
      if (!clipped) begin
        a = base + 12'((bw == 16) ? 2 * r : r);
        bits[15:8] = mem[a];
        a = a + 12'd1;
        bits[7:0] = (bw == 16) ? mem[a] : 8'h00;
        for (int unsigned p = 0; p < bw; p++) begin
          if (bits[15-p]) begin
            px = x0 + p;
            skip = 0;
            if (px >= w) begin
`ifdef SPRITE_WRAP_EN
              px = px - w;
`else
              skip = 1;
`endif
            end
            if (!skip) begin
              wd = py * 8 + px / 16;
              bp = 15 - px % 16;
              if (ref_fb[wd][bp]) coll = 1;
              ref_fb[wd][bp] = ~ref_fb[wd][bp];
            end
          end
        end
        drawn++;
      end
    end
    cyc = clipped ? drawn * per + 2 : rows * per + 1;
  endtask

  task automatic compare_fb(input string nm);
    int unsigned nmis = 0;
    int          first = -1;
    for (int i = 0; i < 512; i++) begin
      if (fb[i] !== ref_fb[i]) begin
        nmis++;
        if (first < 0) first = i;
      end
    end
    check(nm, nmis, 0);
    if (nmis != 0) $display("  %s: first differing word %0d got %h model %h", nm, first, fb[first], ref_fb[first]);
  endtask

  task automatic run_draw(input string nm, input bit hi, input logic [6:0] xi,
                          input logic [5:0] yi, input logic [3:0] ni,
                          input logic [11:0] base, input bit poke);
    int unsigned cyc;
    bit          seen;
    exp_t        e;
    @(negedge clk);
    hires = hi; x = xi; y = yi; n = ni; i_addr = base; start = 1'b1;
    @(posedge clk);
    cyc = 0;
    seen = 0;
    while (!seen && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        start = 1'b0;
        check({nm, "_busy_rise"}, busy, 1);
      end
      if (poke && cyc == 3) begin
        start = 1'b1;
        x = xi + 7'd3;
        n = ni + 4'd1;
      end
      if (poke && cyc == 4) start = 1'b0;
      if (done) seen = 1;
    end
    e = exp_q.pop_front();
    check({nm, "_done_cycle"}, cyc, e.cyc);
    check({nm, "_collision"}, collision, e.coll);
    @(negedge clk);
    check({nm, "_done_pulse"}, done, 0);
    check({nm, "_busy_fall"}, busy, 0);
    check({nm, "_coll_hold"}, collision, e.coll);
  endtask

  initial begin
    bit          mc;
    int unsigned mcyc;
    logic [6:0]  rx;
    logic [5:0]  ry;
    logic [3:0]  rn;
    logic [11:0] rb;
    bit          rh;

    for (int i = 0; i < 4096; i++) mem[i] = '0;
    mem[12'h200] = 8'hF0;
    mem[12'h210] = 8'hFF;
    mem[12'h211] = 8'hFF;
    mem[12'h212] = 8'hFF;
    for (int i = 12'h220; i < 12'h240; i++) mem[i] = 8'hFF;
    for (int i = 12'h240; i < 12'h2A0; i++) mem[i] = 8'($urandom);
    mem[12'hFFF] = 8'hA5;
    mem[12'h000] = 8'h3C;
    for (int i = 0; i < 512; i++) ref_fb[i] = '0;

    tbl[0] = '{1, 1, 7'd0,   6'd0,  4'd1, 12'h200,   7, 0, 9'd0,   16'hF000, 9'd1,   16'h0000};
    tbl[1] = '{0, 1, 7'd0,   6'd0,  4'd1, 12'h200,   7, 1, 9'd0,   16'h0000, 9'd1,   16'h0000};
    tbl[2] = '{0, 1, 7'd12,  6'd3,  4'd1, 12'h210,   7, 0, 9'd24,  16'h000F, 9'd25,  16'hF000};
`ifdef SPRITE_WRAP_EN
    tbl[3] = '{0, 1, 7'd120, 6'd63, 4'd2, 12'h210,  13, 0, 9'd511, 16'h00FF, 9'd504, 16'hFF00};
    tbl[5] = '{1, 0, 7'd60,  6'd31, 4'd2, 12'h210,  13, 0, 9'd251, 16'h000F, 9'd248, 16'hF000};
`else
    tbl[3] = '{0, 1, 7'd120, 6'd63, 4'd2, 12'h210,   8, 0, 9'd511, 16'h00FF, 9'd504, 16'h0000};
    tbl[5] = '{1, 0, 7'd60,  6'd31, 4'd2, 12'h210,   8, 0, 9'd251, 16'h000F, 9'd252, 16'h0000};
`endif
    tbl[4] = '{1, 1, 7'd8,   6'd0,  4'd0, 12'h220, 113, 0, 9'd0,   16'h00FF, 9'd121, 16'hFF00};
    tbl[6] = '{1, 0, 7'd100, 6'd40, 4'd1, 12'h200,   7, 0, 9'd66,  16'h0F00, 9'd67,  16'h0000};

    res = 1'b0; hires = 1'b0; start = 1'b0; x = '0; y = '0; n = '0; i_addr = '0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_coll", collision, 0);
    check("rst_mem_rd", mem_rd, 0);
    check("rst_fbuf_we", fbuf_we, 0);
    check("rst_addrs", {fbuf_addr, mem_addr}, 0);
    check("rst_wdata", fbuf_wdata, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    res = 1'b1;
    clear_fb();

    for (int i = 0; i < 7; i++) begin
      if (tbl[i].clr) clear_fb();
      model_draw(tbl[i].hi, tbl[i].x, tbl[i].y, tbl[i].n, tbl[i].base, mc, mcyc);
      exp_q.push_back('{cyc: tbl[i].cyc, coll: tbl[i].coll});
      run_draw($sformatf("t%0d", i), tbl[i].hi, tbl[i].x, tbl[i].y, tbl[i].n, tbl[i].base, 0);
      check($sformatf("t%0d_word%0d", i, tbl[i].a0), fb[tbl[i].a0], tbl[i].v0);
      check($sformatf("t%0d_word%0d", i, tbl[i].a1), fb[tbl[i].a1], tbl[i].v1);
      compare_fb($sformatf("t%0d_fb_model", i));
    end

    // Reset asserted during WR0 of the second row.
    clear_fb();
    @(negedge clk);
    hires = 1'b1; x = 7'd0; y = 6'd0; n = 4'd3; i_addr = 12'h210; start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
    end
    check("rst_mid_we_before", fbuf_we, 1);
    res = 1'b0;
    #1;
    check("rst_mid_we", fbuf_we, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    check("rst_mid_mem_rd", mem_rd, 0);
    check("rst_mid_addrs", {fbuf_addr, mem_addr}, 0);
    check("rst_mid_wdata", fbuf_wdata, 0);
    repeat (2) @(negedge clk);
    check("rst_mid_word0", fb[0], 16'hFF00);
    check("rst_mid_word1", fb[1], 16'h0000);
    check("rst_mid_word8", fb[8], 16'h0000);
    check("rst_mid_word9", fb[9], 16'h0000);
    res = 1'b1;

    // Random draws against the model, including a pointer wrap and a start while busy.
    clear_fb();
    model_draw(1, 7'd40, 6'd10, 4'd2, 12'hFFF, mc, mcyc);
    exp_q.push_back('{cyc: mcyc, coll: mc});
    run_draw("ptr_wrap", 1, 7'd40, 6'd10, 4'd2, 12'hFFF, 0);
    compare_fb("ptr_wrap_fb_model");
    for (int i = 0; i < 10; i++) begin
      rh = 1'($urandom);
      rx = 7'($urandom);
      ry = 6'($urandom);
      rn = 4'($urandom);
      rb = 12'h240 + 12'($urandom_range(0, 31));
      model_draw(rh, rx, ry, rn, rb, mc, mcyc);
      exp_q.push_back('{cyc: mcyc, coll: mc});
      run_draw($sformatf("rnd%0d", i), rh, rx, ry, rn, rb, i == 2);
      compare_fb($sformatf("rnd%0d_fb_model", i));
    end

    check("we_outside_busy", we_viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
